// File: rtl/smart_sensor_frontend.sv
// Sensor front end: 2-FF synchronizers, per-contact debouncers and a serial temperature receiver.
// Define SENSOR_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module smart_sensor_frontend #(
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter int         BIT_CYCLES      = 8,
   parameter logic [6:0] ST_INIT         = 7'd60
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       raw_fd,
   input  logic       raw_rd,
   input  logic       raw_w,
   input  logic       raw_fa,
   input  logic       temp_sdi,
   output logic       SFD,
   output logic       SRD,
   output logic       SW,
   output logic       SFA,
   output logic [6:0] ST,
   output logic       st_update,
   output logic       temp_err,
   output logic [2:0] rx_state_dbg
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BIT_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BIT_CYCLES / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } rx_state_e;

   logic [3:0]    raw_s1_q, raw_s2_q;
   logic          rx_s1_q, rx_s2_q;
   logic [3:0]    deb_q, deb_d;
   logic [DW-1:0] dcnt_q [4];
   logic [DW-1:0] dcnt_d [4];

   rx_state_e     state_q, state_d;
   logic [BW-1:0] tick_q, tick_d;
   logic [2:0]    nbit_q, nbit_d;
   logic [6:0]    shift_q, shift_d;
   logic [6:0]    st_q, st_d;
   logic          upd_q, upd_d;
   logic          err_q, err_d;
   logic          armed_q, armed_d;
   logic          stop_ok;
   logic          rx;
`ifdef SENSOR_PARITY_EN
   logic          par_err_q, par_err_d;
`endif

   assign rx = rx_s2_q;

   // The serial line idles high, so its synchronizer resets to 1 to avoid a phantom start bit.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         raw_s1_q <= '0;
         raw_s2_q <= '0;
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
      end else begin
         raw_s1_q <= {raw_fa, raw_w, raw_rd, raw_fd};
         raw_s2_q <= raw_s1_q;
         rx_s1_q  <= temp_sdi;
         rx_s2_q  <= rx_s1_q;
      end
   end

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 4; i++) begin
         dcnt_d[i] = '0;
         if (raw_s2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DEB_LAST) begin
               deb_d[i] = raw_s2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         deb_q <= '0;
         for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
      end
   end

   // armed_q drops after a low stop bit so a held-low line (break) cannot retrigger a frame.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      nbit_d  = nbit_q;
      shift_d = shift_q;
      st_d    = st_q;
      upd_d   = 1'b0;
      err_d   = 1'b0;
      armed_d = armed_q;
`ifdef SENSOR_PARITY_EN
      par_err_d = par_err_q;
      stop_ok   = rx && !par_err_q;
`else
      stop_ok   = rx;
`endif
      case (state_q)
         S_IDLE: begin
            tick_d  = '0;
            nbit_d  = '0;
            armed_d = armed_q | rx;
`ifdef SENSOR_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (armed_q && !rx) state_d = S_START;
         end
         S_START: begin
            if (tick_q == HALF_LAST) begin
               tick_d  = '0;
               state_d = rx ? S_IDLE : S_DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               shift_d = {shift_q[5:0], rx};
               nbit_d  = nbit_q + 1'b1;
               if (nbit_q == 3'd6) begin
`ifdef SENSOR_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`ifdef SENSOR_PARITY_EN
         S_PAR: begin
            if (tick_q == BIT_LAST) begin
               tick_d    = '0;
               par_err_d = ^{shift_q, rx};
               state_d   = S_STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               state_d = S_IDLE;
               armed_d = rx;
               if (stop_ok) begin
                  st_d  = shift_q;
                  upd_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         nbit_q    <= '0;
         shift_q   <= '0;
         st_q      <= ST_INIT;
         upd_q     <= 1'b0;
         err_q     <= 1'b0;
         armed_q   <= 1'b1;
`ifdef SENSOR_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         nbit_q    <= nbit_d;
         shift_q   <= shift_d;
         st_q      <= st_d;
         upd_q     <= upd_d;
         err_q     <= err_d;
         armed_q   <= armed_d;
`ifdef SENSOR_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign SFD          = deb_q[0];
   assign SRD          = deb_q[1];
   assign SW           = deb_q[2];
   assign SFA          = deb_q[3];
   assign ST           = st_q;
   assign st_update    = upd_q;
   assign temp_err     = err_q;
   assign rx_state_dbg = state_q;

endmodule

// File: tb/tb_smart_sensor_frontend.sv
// Bench for smart_sensor_frontend: per-cycle reference model (sliding-window debounce, scheduled
// frame outcomes) plus a frame table and hand-written reset/debounce/glitch/break sequences.
module tb_smart_sensor_frontend;

   localparam int         DEB  = 16;
   localparam int         BIT  = 8;
   localparam logic [6:0] INIT = 7'd60;
`ifdef SENSOR_PARITY_EN
   localparam int FRAME_BITS = 9;
`else
   localparam int FRAME_BITS = 8;
`endif
   // Start edge at the pin to stop-bit sample (= ST load edge).
   localparam int LAT = 2 + BIT / 2 + FRAME_BITS * BIT;

   logic       clk, Rst, sdi;
   logic [3:0] raw;
   logic       SFD, SRD, SW, SFA, st_update, temp_err;
   logic [6:0] ST;
   logic [2:0] rx_state_dbg;

   smart_sensor_frontend #(
      .DEBOUNCE_CYCLES(DEB),
      .BIT_CYCLES     (BIT),
      .ST_INIT        (INIT)
   ) dut (
      .clk         (clk),
      .Rst         (Rst),
      .raw_fd      (raw[0]),
      .raw_rd      (raw[1]),
      .raw_w       (raw[2]),
      .raw_fa      (raw[3]),
      .temp_sdi    (sdi),
      .SFD         (SFD),
      .SRD         (SRD),
      .SW          (SW),
      .SFA         (SFA),
      .ST          (ST),
      .st_update   (st_update),
      .temp_err    (temp_err),
      .rx_state_dbg(rx_state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_bad = 0;
   int unsigned cyc   = 0;
   logic        mdl_rst = 1'b1;
   logic [3:0]  hist_q[$];
   logic [39:0] exp_q[$];   // {edge number, frame ok, value}
   logic [3:0]  exp_c;
   logic [6:0]  exp_st;
   logic        exp_upd, exp_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Contact rule: an output flips once the last DEB synchronized views (pin two edges
   // earlier) all disagree with it. Frame outcomes come from the schedule in exp_q.
   always @(posedge clk) begin
      logic        all_diff;
      logic [39:0] head;
      cyc++;
      mdl_rst = Rst;
      if (Rst) begin
         hist_q.delete();
         for (int j = 0; j < DEB + 2; j++) hist_q.push_back(4'b0);
         exp_c   = '0;
         exp_st  = INIT;
         exp_upd = 1'b0;
         exp_err = 1'b0;
         exp_q.delete();
      end else begin
         hist_q.push_back(raw);
         void'(hist_q.pop_front());
         for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (hist_q[j][i] == exp_c[i]) all_diff = 1'b0;
            if (all_diff) exp_c[i] = ~exp_c[i];
         end
         exp_upd = 1'b0;
         exp_err = 1'b0;
         if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[39:8] == cyc) begin
               void'(exp_q.pop_front());
               if (head[7]) begin
                  exp_upd = 1'b1;
                  exp_st  = head[6:0];
               end else begin
                  exp_err = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!mdl_rst) begin
         check("contacts", {SFA, SW, SRD, SFD}, exp_c);
         check("ST", ST, exp_st);
         check("st_update", st_update, exp_upd);
         check("temp_err", temp_err, exp_err);
      end
   end

   // ---------------- driver tasks (called positioned at a negedge) ----------------
   task automatic drive_bit(input logic v);
      sdi = v;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [6:0] d, input logic stop, input logic flip,
                             input int gap, input logic ok);
      exp_q.push_back({32'(cyc + 1 + LAT), ok, d});
      drive_bit(1'b0);
      for (int b = 6; b >= 0; b--) drive_bit(d[b]);
`ifdef SENSOR_PARITY_EN
      drive_bit((^d) ^ flip);
`else
      if (flip) sdi = 1'b1;
`endif
      drive_bit(stop);
      sdi = 1'b1;
      repeat (gap * BIT) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      logic [6:0] data;
      logic       stop;
      logic       flip;
      int         gap;
      logic       exp_upd;
      logic [6:0] exp_st;
   } frame_vec_t;

   frame_vec_t tbl[6];
   logic       frames_done;

   initial begin
      logic [6:0] rd;
      logic       rs, rf, rok;
      int         rg, idx;

      tbl[0] = '{7'd75,  1'b1, 1'b0, 2, 1'b1, 7'd75};
      tbl[1] = '{7'd40,  1'b0, 1'b0, 2, 1'b0, 7'd75};
`ifdef SENSOR_PARITY_EN
      tbl[2] = '{7'd45,  1'b1, 1'b0, 1, 1'b1, 7'd45};
      tbl[3] = '{7'd45,  1'b1, 1'b1, 2, 1'b0, 7'd45};
`else
      tbl[2] = '{7'd0,   1'b1, 1'b0, 1, 1'b1, 7'd0};
      tbl[3] = '{7'd127, 1'b1, 1'b0, 1, 1'b1, 7'd127};
`endif
      tbl[4] = '{7'd49,  1'b1, 1'b0, 0, 1'b1, 7'd49};
      tbl[5] = '{7'd71,  1'b1, 1'b0, 2, 1'b1, 7'd71};

      Rst = 1'b1;
      raw = '0;
      sdi = 1'b1;
      repeat (3) @(negedge clk);
      check("reset contacts", {SFA, SW, SRD, SFD}, 4'b0);
      check("reset ST", ST, INIT);
      check("reset pulses", {st_update, temp_err}, 2'b0);
      Rst = 1'b0;
      repeat (5) @(negedge clk);

      // Reset in the middle of a frame and with a contact already debounced high.
      raw[0] = 1'b1;
      sdi    = 1'b0;
      repeat (20) @(negedge clk);
      check("SFD before reset", SFD, 1'b1);
      #2 Rst = 1'b1;
      #1;
      check("mid reset contacts", {SFA, SW, SRD, SFD}, 4'b0);
      check("mid reset ST", ST, INIT);
      check("mid reset pulses", {st_update, temp_err}, 2'b0);
      check("mid reset fsm idle", rx_state_dbg, 3'd0);
      raw = '0;
      sdi = 1'b1;
      repeat (2) @(negedge clk);
      Rst = 1'b0;
      repeat (30) @(negedge clk);
      check("idle after reset ST", ST, INIT);

      // Debounce: DEB-1 cycle glitch is filtered; a held step lands exactly 2+DEB cycles later.
      raw[0] = 1'b1;
      repeat (DEB - 1) @(negedge clk);
      raw[0] = 1'b0;
      repeat (25) @(negedge clk);
      check("SFD after short glitch", SFD, 1'b0);
      raw[0] = 1'b1;
      repeat (DEB + 1) @(negedge clk);
      check("SFD one cycle early", SFD, 1'b0);
      @(negedge clk);
      check("SFD at latency", SFD, 1'b1);
      repeat (2) @(negedge clk);
      raw[0] = 1'b0;
      repeat (25) @(negedge clk);
      check("SFD released", SFD, 1'b0);

      // Frame table, including a framing error and a back-to-back pair.
      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].data, tbl[i].stop, tbl[i].flip, tbl[i].gap, tbl[i].exp_upd);
         check("ST after table frame", ST, tbl[i].exp_st);
      end
      repeat (2 * BIT) @(negedge clk);

      // Two-cycle low glitch on the idle line is a false start: nothing happens.
      sdi = 1'b0;
      repeat (2) @(negedge clk);
      sdi = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      check("ST after line glitch", ST, tbl[5].exp_st);
      check("fsm idle after glitch", rx_state_dbg, 3'd0);

      // Break: one temp_err, then no rearm until the line goes high again.
      exp_q.push_back({32'(cyc + 1 + LAT), 1'b0, 7'd0});
      sdi = 1'b0;
      repeat (15 * BIT) @(negedge clk);
      sdi = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("ST after break", ST, tbl[5].exp_st);
      send_frame(7'd33, 1'b1, 1'b0, 1, 1'b1);
      check("ST after break recovery", ST, 7'd33);

      // Random frames with concurrent random contact activity.
      frames_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 14; f++) begin
               rd = 7'($urandom_range(0, 127));
               rs = ($urandom_range(0, 4) != 0);
               rf = ($urandom_range(0, 4) == 0);
               rg = $urandom_range(0, 2);
               if (!rs && rg == 0) rg = 1;
`ifdef SENSOR_PARITY_EN
               rok = rs && !rf;
`else
               rok = rs;
`endif
               send_frame(rd, rs, rf, rg, rok);
            end
            frames_done = 1'b1;
         end
         begin
            while (!frames_done) begin
               idx = $urandom_range(0, 3);
               raw[idx] = ~raw[idx];
               repeat ($urandom_range(1, 30)) @(negedge clk);
            end
         end
      join
      raw = '0;
      repeat (60) @(negedge clk);
      check("scheduled frames all seen", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/smart_sensor_frontend.md
# smart_sensor_frontend

Conditions the raw smart-home sensor signals into the clean, single-clock sensor bus consumed by the home controller FSM (SFD, SRD, SW, SFA, ST[6:0]). It synchronizes and debounces the four contact/alarm sensors, and receives the 7-bit temperature reading from a UART-style serial thermometer line. ST is held stable between complete, valid frames. The block sits between the board pins and the controller's sensor inputs.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a contact output changes (≥2).
- BIT_CYCLES, 8: clock cycles per serial bit on temp_sdi (≥4, even).
- ST_INIT, 7'd60: ST value after reset and before the first valid frame (comfort band).
- clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  asynchronous reset, active-high.
- raw_fd, raw_rd, raw_w, raw_fa  in  1 each  raw front-door, rear-door, window and fire-alarm contacts (asynchronous).
- temp_sdi  in  1  serial temperature line (asynchronous); idle high.
- SFD, SRD, SW, SFA  out  1 each  debounced sensor levels for the controller.
- ST  out  7  last valid temperature reading, unsigned.
- st_update  out  1  one-cycle pulse when ST is loaded.
- temp_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Every asynchronous input (raw_*, temp_sdi) passes a 2-FF synchronizer; synchronizer flops reset to 0 (raw_*) / 1 (temp_sdi).
- Debouncer per contact: when synced input ≠ output, a counter increments; on reaching DEBOUNCE_CYCLES-1 with input still different, the output takes the input value and the counter clears. Any cycle with input = output clears the counter. Glitches shorter than DEBOUNCE_CYCLES never reach the output.
- Serial receiver FSM: IDLE, START, DATA, PAR, STOP.
  - IDLE: synced falling level (0) -> START, bit counter cleared.
  - START: at mid-bit (BIT_CYCLES/2 cycles in) resample; 0 -> DATA, 1 -> IDLE silently (false start, no temp_err).
  - DATA: sample every BIT_CYCLES at mid-bit, 7 bits, MSB first into a shift register; after bit 0 -> PAR if SENSOR_PARITY_EN defined, else STOP.
  - PAR: sample parity bit; mismatch flag latched.
  - STOP: sample stop bit; 1 and no parity mismatch -> ST ≤ shift register, st_update pulse; otherwise ST unchanged, temp_err pulse. Always -> IDLE.
- ST, st_update, temp_err are registered; no combinational path from any input to any output.

## Timing
- Reset: SFD=SRD=SW=SFA=0, ST=ST_INIT, st_update=0, temp_err=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame; ST stays ST_INIT.
- Contact latency: input step to output change = 2 (sync) + DEBOUNCE_CYCLES cycles.
- Temperature latency: ST and st_update change in the cycle after the stop-bit sample, i.e. 2 + (BIT_CYCLES/2) + (8 or 9)·BIT_CYCLES cycles after the start edge at the pin.
- A new start bit is accepted the cycle after returning to IDLE; back-to-back frames with one stop bit are received without loss.
- st_update and temp_err are mutually exclusive and never asserted for more than one cycle.
- Line held low (break): frame ends with temp_err, then FSM waits in IDLE until line returns high before arming a new start.

## Configuration
- SENSOR_PARITY_EN defined: frame = start + 7 data + even parity (XOR of data bits and parity = 0) + stop; parity mismatch -> temp_err, ST kept.
- Not defined: frame = start + 7 data + stop; PAR state is unreachable and parity logic is absent.

## Test plan
- Reset: Rst high mid-activity -> all contacts 0, ST=60, pulses 0; release and hold raw inputs idle -> outputs unchanged.
- Debounce: raw_fd high for DEBOUNCE_CYCLES-1 cycles then low -> SFD stays 0; held high 20 cycles -> SFD rises exactly 2+16 cycles after the edge.
- Frame: send 7'd75 (no parity build) -> ST=75 with single st_update pulse at the computed latency; ST holds 75 afterward.
- Framing error: send 7'd40 with stop bit 0 -> temp_err pulse, ST unchanged at prior value; 2-cycle low glitch on idle line -> no pulse at all.
- Parity (SENSOR_PARITY_EN): 7'd45 with correct parity -> ST=45; same data with flipped parity -> temp_err, ST stays 45.
- Back-to-back: frames 7'd49 then 7'd71 with no idle gap -> two st_update pulses, ST=49 then 71; concurrent raw_fa toggle debounced independently.
